mm_host_driver: RTL and testbench
=================================

// Module: mm_host_driver
// PURPOSE
//  Initiator-side driver for the 4x4 matrix-multiply accelerator. Holds 32 input words (B then A) and a 16-word result buffer.
//  On go: writes ap_start over AXI-Lite, streams the 32 words out over AXI-Stream, and captures 16 results from the return stream.
//  Then polls ap_done over AXI-Lite and clears ap_start. Sits between the firmware/host register port and the accelerator.
// PARAMETERS
//  pADDR_WIDTH  12     AXI-Lite address width
//  pDATA_WIDTH  32     data width (lite and stream)
//  CTRL_ADDR    'h000  accelerator ap_ctrl register address
//  POLL_GAP     4      idle cycles between consecutive ap_ctrl reads (>=1)
//  MAX_POLLS    64     ap_ctrl reads before timeout error
// PORTS
//  axis_clk     in   1    clock
//  axis_rst_n   in   1    reset, asynchronous, active-low
//  host_we      in   1    write input buffer word (ignored while busy)
//  host_waddr   in   5    input buffer index 0..31 (0..15 = B, 16..31 = A)
//  host_wdata   in   32   input word
//  host_raddr   in   4    result buffer index
//  host_rdata   out  32   result word, combinational from host_raddr
//  go           in   1    start pulse (ignored while busy)
//  busy         out  1    run in progress
//  done         out  1    sticky; run finished, cleared by next accepted go
//  err          out  1    sticky; poll timeout, cleared by next accepted go
//  awvalid/awready/awaddr  out/in/out 1/1/pADDR_WIDTH  lite write address
//  wvalid/wready/wdata     out/in/out 1/1/pDATA_WIDTH  lite write data
//  arvalid/arready/araddr  out/in/out 1/1/pADDR_WIDTH  lite read address
//  rvalid/rready/rdata     in/out/in  1/1/pDATA_WIDTH  lite read data
//  sm_tvalid/sm_tready/sm_tdata/sm_tlast  out/in/out/out  stream to accelerator
//  ss_tvalid/ss_tready/ss_tdata/ss_tlast  in/out/in/in    results from accelerator
// BEHAVIOUR
//  Reset: all valids, rready, ss_tready, busy, done, err = 0; awaddr/araddr = CTRL_ADDR; FSM=IDLE; counters 0. Buffers are not reset.
//  FSM: IDLE -go-> WR_START -> STREAM -> WAIT_OUT -> POLL -> CLR -> FIN(done=1) -> IDLE.
//  WR_START/CLR: awvalid and wvalid asserted together, wdata=1 (WR_START) or 0 (CLR). Each valid drops
//   the cycle after its own ready is seen high. The state exits once both are accepted, in any order or simultaneously.
//  STREAM: sm_tdata = buf[tx_cnt]. A beat transfers on sm_tvalid&&sm_tready. sm_tlast=1 only on tx_cnt==31.
//   tdata/tlast are held stable while stalled. After the beat at index 31, go to WAIT_OUT.
//  Result capture runs in STREAM and WAIT_OUT: ss_tready = (rx_cnt<16). Each beat writes res[rx_cnt] and increments rx_cnt.
//   ss_tlast is ignored. Beats after the 16th are not accepted. WAIT_OUT exits when rx_cnt==16 (may be immediate).
//  POLL: wait POLL_GAP cycles, assert arvalid (held until arready), then rready=1 until rvalid.
//   If rdata[1] (ap_done) is set, go to CLR; else increment poll_cnt and repeat.
//   If poll_cnt reaches MAX_POLLS with ap_done clear: set err=1, skip CLR, go to FIN.
//  FIN: done=1 for this run (held until next accepted go); busy=0 in IDLE/FIN. busy=1 from the cycle after go until FIN.
//  go in the same cycle as host_we: the write is taken, then the run starts next cycle with updated data.
//  Asynchronous reset mid-run aborts immediately. No further lite/stream beats; the next go restarts from word 0.
//  Widths: tx_cnt 6b, rx_cnt 5b, poll_cnt >= clog2(MAX_POLLS+1); no wrap within a run.
// TESTING
//  1. B=identity, A=1..16, go -> one lite write wdata=1; 32 stream beats, tlast only on beat 31;
//     res[i]=i+1; lite write wdata=0; done=1, err=0.
//  2. sm_tready toggling 1,0,0,1 -> beat order and values unchanged; sm_tdata stable during stall cycles; 32 beats total.
//  3. awready delayed 3 cycles, wready immediate -> wvalid high 1 cycle, awvalid 4 cycles, exactly one write accepted.
//  4. rdata[1] held 0 -> exactly MAX_POLLS=64 reads spaced >=POLL_GAP, then err=1, done=1, no clear write.
//  5. axis_rst_n low after 10 stream beats -> all valids 0 asynchronously; new go resends from buf[0].
//  6. go and host_we during busy -> ignored: buffer unchanged, no second run; results appear in res[0..15] only once.

Source files
------------

// File: rtl/mm_host_driver.sv
// Host-side driver for the 4x4 matrix-multiply accelerator.
// Holds 32 input words (B then A) and 16 result words. A run starts the
// accelerator over AXI-Lite, streams the inputs out, and captures the results.
// It then polls ap_done and clears ap_start.
//
// Handshake rule for every channel: a beat transfers on the rising edge where
// valid && ready are both high. A valid, once raised, stays high with stable
// payload until that edge. The driver's own readies do not depend on the
// partner's valid.
module mm_host_driver #(
  parameter int                     pADDR_WIDTH = 12,
  parameter int                     pDATA_WIDTH = 32,
  parameter logic [pADDR_WIDTH-1:0] CTRL_ADDR   = '0,
  parameter int                     POLL_GAP    = 4,
  parameter int                     MAX_POLLS   = 64
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  // host register port
  input  logic                   host_we,
  input  logic [4:0]             host_waddr,
  input  logic [pDATA_WIDTH-1:0] host_wdata,
  input  logic [3:0]             host_raddr,
  output logic [pDATA_WIDTH-1:0] host_rdata,
  input  logic                   go,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  // AXI-Lite initiator
  output logic                   awvalid,
  input  logic                   awready,
  output logic [pADDR_WIDTH-1:0] awaddr,
  output logic                   wvalid,
  input  logic                   wready,
  output logic [pDATA_WIDTH-1:0] wdata,
  output logic                   arvalid,
  input  logic                   arready,
  output logic [pADDR_WIDTH-1:0] araddr,
  input  logic                   rvalid,
  output logic                   rready,
  input  logic [pDATA_WIDTH-1:0] rdata,
  // stream to accelerator
  output logic                   sm_tvalid,
  input  logic                   sm_tready,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  // stream from accelerator
  input  logic                   ss_tvalid,
  output logic                   ss_tready,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  // FSM state, for observation
  output logic [2:0]             dbg_state
);

  localparam int POLL_W = $clog2(MAX_POLLS + 1);
  localparam int GAP_W  = $clog2(POLL_GAP + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_START = 3'd1,
    S_STREAM   = 3'd2,
    S_WAIT_OUT = 3'd3,
    S_POLL     = 3'd4,
    S_CLR      = 3'd5,
    S_FIN      = 3'd6
  } state_t;

  state_t                   state, state_nxt;
  logic [pDATA_WIDTH-1:0]   in_buf  [32];
  logic [pDATA_WIDTH-1:0]   res_buf [16];
  logic [5:0]               tx_cnt;
  logic [4:0]               rx_cnt;
  logic [POLL_W-1:0]        poll_cnt;
  logic [GAP_W-1:0]         gap_cnt;

  logic go_ok, aw_hs, w_hs, ar_hs, r_hs, sm_hs, ss_hs;
  logic lite_wr_done, poll_last, enter_wr, enter_fin;

  // ss_tlast is not needed (the result count is fixed); only ap_done is read from rdata
  logic unused_bits;
  assign unused_bits = ^{ss_tlast, rdata};

  assign go_ok  = go && (state == S_IDLE || state == S_FIN);
  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rready && rvalid;
  assign sm_hs  = sm_tvalid && sm_tready;
  assign ss_hs  = ss_tvalid && ss_tready;

  // Both lite write channels are done once each valid is gone or handshaking now
  assign lite_wr_done = (!awvalid || aw_hs) && (!wvalid || w_hs);
  assign poll_last    = (poll_cnt == POLL_W'(MAX_POLLS - 1));
  assign enter_wr     = (state_nxt == S_WR_START && state != S_WR_START) ||
                        (state_nxt == S_CLR && state != S_CLR);
  assign enter_fin    = (state_nxt == S_FIN && state != S_FIN);

  assign awaddr     = CTRL_ADDR;
  assign araddr     = CTRL_ADDR;
  assign wdata      = (state == S_WR_START) ? pDATA_WIDTH'(1) : '0;
  assign sm_tvalid  = (state == S_STREAM);
  assign sm_tdata   = in_buf[tx_cnt[4:0]];
  assign sm_tlast   = sm_tvalid && (tx_cnt == 6'd31);
  assign ss_tready  = (state == S_STREAM || state == S_WAIT_OUT) && (rx_cnt < 5'd16);
  assign busy       = !(state == S_IDLE || state == S_FIN);
  assign host_rdata = res_buf[host_raddr];
  assign dbg_state  = state;

  // State register; reset aborts any run in progress
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) state <= S_IDLE;
    else             state <= state_nxt;
  end

  // Next-state sequencing of one run
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (go_ok) state_nxt = S_WR_START;
      S_FIN:      state_nxt = go_ok ? S_WR_START : S_IDLE;
      S_WR_START: if (lite_wr_done) state_nxt = S_STREAM;
      S_STREAM:   if (sm_hs && tx_cnt == 6'd31) state_nxt = S_WAIT_OUT;
      S_WAIT_OUT: if (rx_cnt == 5'd16) state_nxt = S_POLL;
      S_POLL: begin
        if (r_hs) begin
          if (rdata[1])       state_nxt = S_CLR;
          else if (poll_last) state_nxt = S_FIN;
        end
      end
      S_CLR:      if (lite_wr_done) state_nxt = S_FIN;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Lite channel valids, counters, poll pacing and sticky status
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      awvalid  <= 1'b0;
      wvalid   <= 1'b0;
      arvalid  <= 1'b0;
      rready   <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      tx_cnt   <= '0;
      rx_cnt   <= '0;
      poll_cnt <= '0;
      gap_cnt  <= '0;
    end else begin
      if (go_ok) begin
        done     <= 1'b0;
        err      <= 1'b0;
        tx_cnt   <= '0;
        rx_cnt   <= '0;
        poll_cnt <= '0;
        gap_cnt  <= '0;
      end
      if (enter_wr) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
      end else begin
        if (aw_hs) awvalid <= 1'b0;
        if (w_hs)  wvalid  <= 1'b0;
      end
      if (sm_hs) tx_cnt <= tx_cnt + 6'd1;
      if (ss_hs) rx_cnt <= rx_cnt + 5'd1;
      if (state == S_POLL) begin
        // idle gap before each ap_ctrl read
        if (!arvalid && !rready) begin
          if (gap_cnt == GAP_W'(POLL_GAP - 1)) begin
            gap_cnt <= '0;
            arvalid <= 1'b1;
          end else begin
            gap_cnt <= gap_cnt + GAP_W'(1);
          end
        end
        if (ar_hs) begin
          arvalid <= 1'b0;
          rready  <= 1'b1;
        end
        if (r_hs) begin
          rready <= 1'b0;
          if (!rdata[1]) begin
            poll_cnt <= poll_cnt + POLL_W'(1);
            if (poll_last) err <= 1'b1;
          end
        end
      end
      if (enter_fin) done <= 1'b1;
    end
  end

  // Input buffer: host writes land only while no run is in progress
  always_ff @(posedge axis_clk) begin
    if (host_we && !busy) in_buf[host_waddr] <= host_wdata;
  end

  // Result buffer: each accepted return beat fills the next slot
  always_ff @(posedge axis_clk) begin
    if (ss_hs) res_buf[rx_cnt[3:0]] <= ss_tdata;
  end

endmodule

// File: tb/tb_mm_host_driver.sv
// Bench for mm_host_driver: a behavioural accelerator (AXI-Lite ctrl register
// plus a 4x4 multiply on the received stream) and directed runs with
// randomized data and backpressure.
module tb_mm_host_driver;

  localparam int POLL_GAP  = 4;
  localparam int MAX_POLLS = 64;

  logic        axis_clk, axis_rst_n;
  logic        host_we;
  logic [4:0]  host_waddr;
  logic [31:0] host_wdata;
  logic [3:0]  host_raddr;
  logic [31:0] host_rdata;
  logic        go, busy, done, err;
  logic        awvalid, awready, wvalid, wready, arvalid, arready, rvalid, rready;
  logic [11:0] awaddr, araddr;
  logic [31:0] wdata, rdata;
  logic        sm_tvalid, sm_tready, sm_tlast, ss_tvalid, ss_tready, ss_tlast;
  logic [31:0] sm_tdata, ss_tdata;
  logic [2:0]  dbg_state;

  mm_host_driver #(.POLL_GAP(POLL_GAP), .MAX_POLLS(MAX_POLLS)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .host_we(host_we), .host_waddr(host_waddr), .host_wdata(host_wdata),
    .host_raddr(host_raddr), .host_rdata(host_rdata),
    .go(go), .busy(busy), .done(done), .err(err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .dbg_state(dbg_state)
  );

  // clock
  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  int n_checks = 0;
  int n_fail   = 0;

  // host-visible input buffer as the design should hold it
  logic [31:0] mem [32];
  bit          model_busy;

  // bus-side observations and accelerator configuration
  logic [31:0] sm_data_q[$];
  logic        sm_last_q[$];
  logic [31:0] w_data_q[$];
  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  int aw_count, ar_count, ss_count, awv_cyc, wv_cyc;
  int ar_cyc_last, ar_gap_min, cyc;
  int src_idx, tready_k, aw_wait, w_wait;
  int tready_mode, aw_delay, w_delay, cur_done_at;
  bit src_loaded, stall_pend;
  logic [31:0] stall_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // C = A * B, B in words 0..15 and A in words 16..31, row-major 4x4
  function automatic logic [31:0] mm_elem(input logic [31:0] w [32], input int idx);
    logic [31:0] acc;
    int r, c;
    acc = 0;
    r = idx / 4;
    c = idx % 4;
    for (int k = 0; k < 4; k++) acc += w[16 + r*4 + k] * w[k*4 + c];
    return acc;
  endfunction

  // accelerator and bus observer: sample on negedge, respond just after posedge
  initial begin : bus_model
    logic aw_hs, w_hs, ar_hs, r_hs, sm_hs, ss_hs;
    logic [31:0] rx_words [32];
    logic [31:0] rd;
    awready = 0; wready = 0; arready = 0; rvalid = 0; rdata = 0;
    sm_tready = 0; ss_tvalid = 0; ss_tdata = 0; ss_tlast = 0;
    forever begin
      @(negedge axis_clk);
      cyc++;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      ar_hs = arvalid && arready;
      r_hs  = rvalid && rready;
      sm_hs = sm_tvalid && sm_tready;
      ss_hs = ss_tvalid && ss_tready;
      if (stall_pend && sm_tvalid) check("sm_stall_hold", sm_tdata, stall_data);
      stall_pend = sm_tvalid && !sm_tready;
      stall_data = sm_tdata;
      if (sm_hs) begin
        sm_data_q.push_back(sm_tdata);
        sm_last_q.push_back(sm_tlast);
      end
      if (aw_hs) aw_count++;
      if (w_hs) w_data_q.push_back(wdata);
      if (ar_hs) begin
        if (ar_count > 0 && cyc - ar_cyc_last < ar_gap_min) ar_gap_min = cyc - ar_cyc_last;
        ar_cyc_last = cyc;
        ar_count++;
      end
      if (ss_hs) ss_count++;
      if (awvalid) awv_cyc++;
      if (wvalid) wv_cyc++;

      @(posedge axis_clk);
      #1;
      awready = awvalid && (aw_wait >= aw_delay);
      aw_wait = awvalid ? aw_wait + 1 : 0;
      wready  = wvalid && (w_wait >= w_delay);
      w_wait  = wvalid ? w_wait + 1 : 0;
      arready = arvalid;
      if (ar_hs) begin
        rd = $urandom;
        rd[1] = (ar_count > cur_done_at);
        rdata = rd;
        rvalid = 1;
      end else if (r_hs) begin
        rvalid = 0;
      end
      case (tready_mode)
        0:       sm_tready = 1;
        1:       sm_tready = (tready_k % 4 == 0) || (tready_k % 4 == 3);
        default: sm_tready = ($urandom_range(0, 1) == 1);
      endcase
      tready_k++;
      if (!src_loaded && sm_data_q.size() == 32) begin
        for (int i = 0; i < 32; i++) rx_words[i] = sm_data_q[i];
        for (int i = 0; i < 16; i++) src_q.push_back(mm_elem(rx_words, i));
        src_q.push_back($urandom);
        src_q.push_back($urandom);
        src_loaded = 1;
      end
      if (ss_hs) src_idx++;
      if (!(ss_tvalid && !ss_hs))
        ss_tvalid = (src_idx < src_q.size()) && (tready_mode != 2 || $urandom_range(0, 1) == 1);
      ss_tdata = (src_idx < src_q.size()) ? src_q[src_idx] : 32'h0;
      ss_tlast = (src_idx == 15);
    end
  end

  // driver tasks: host-side inputs change at negedge + 1
  task automatic host_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge axis_clk); #1;
    host_we = 1; host_waddr = a; host_wdata = d;
    if (!model_busy) mem[a] = d;
    @(negedge axis_clk); #1;
    host_we = 0;
  endtask

  task automatic load_mem();
    for (int i = 0; i < 32; i++) host_write(5'(i), mem[i]);
  endtask

  task automatic start_run(input int mode, input int awd, input int wd, input int da,
                           input bit with_we, input logic [31:0] we_data);
    @(negedge axis_clk); #1;
    sm_data_q.delete(); sm_last_q.delete(); w_data_q.delete(); src_q.delete();
    aw_count = 0; ar_count = 0; ss_count = 0; awv_cyc = 0; wv_cyc = 0;
    ar_gap_min = 1000000; src_idx = 0; src_loaded = 0; stall_pend = 0;
    tready_k = 0; aw_wait = 0; w_wait = 0; rvalid = 0; ss_tvalid = 0;
    tready_mode = mode; aw_delay = awd; w_delay = wd; cur_done_at = da;
    go = 1;
    if (with_we) begin
      host_we = 1; host_waddr = 0; host_wdata = we_data; mem[0] = we_data;
    end
    model_busy = 1;
    @(negedge axis_clk); #1;
    go = 0; host_we = 0;
  endtask

  task automatic wait_end(input string tag, input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge axis_clk); #1;
      n++;
    end
    check(tag, done, 1);
    @(negedge axis_clk); #1;
    model_busy = 0;
  endtask

  // scoreboard for one completed run
  task automatic check_run(input bit timeout);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(mem[i]);
    check("beat_count", sm_data_q.size(), 32);
    for (int i = 0; i < 32; i++) begin
      check("beat_data", sm_data_q[i], exp_q.pop_front());
      check("beat_last", 32'(sm_last_q[i]), 32'(i == 31));
    end
    for (int i = 0; i < 16; i++) begin
      host_raddr = 4'(i); #1;
      check("result", host_rdata, mm_elem(mem, i));
    end
    check("ss_beats", ss_count, 16);
    check("lite_writes", w_data_q.size(), timeout ? 1 : 2);
    check("aw_count", aw_count, timeout ? 1 : 2);
    check("start_wdata", w_data_q[0], 1);
    if (!timeout) check("clear_wdata", w_data_q[w_data_q.size()-1], 0);
    check("poll_reads", ar_count, timeout ? MAX_POLLS : cur_done_at + 1);
    if (ar_count > 1) check("poll_gap_ok", 32'(ar_gap_min >= POLL_GAP), 1);
    check("done", done, 1);
    check("err", err, 32'(timeout));
    check("busy_after", busy, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_sm_tvalid"}, sm_tvalid, 0);
    check({tag, "_ss_tready"}, ss_tready, 0);
  endtask

  initial begin : main
    int n;
    host_we = 0; host_waddr = 0; host_wdata = 0; host_raddr = 0; go = 0;
    model_busy = 0; tready_mode = 0; aw_delay = 0; w_delay = 0; cur_done_at = 0;
    axis_rst_n = 0;
    repeat (3) @(negedge axis_clk);
    check_idle("reset");
    check("reset_done", done, 0);
    check("reset_err", err, 0);
    check("reset_awaddr", 32'(awaddr), 0);
    check("reset_araddr", 32'(araddr), 0);
    #1 axis_rst_n = 1;

    // run 1: B = identity, A = 1..16, so C = A
    for (int i = 0; i < 16; i++) mem[i] = (i / 4 == i % 4) ? 32'd1 : 32'd0;
    for (int i = 0; i < 16; i++) mem[16 + i] = 32'(i + 1);
    load_mem();
    start_run(0, 0, 0, 0, 0, 0);
    wait_end("run1_end", 500);
    check_run(0);
    for (int i = 0; i < 16; i++) begin
      host_raddr = 4'(i); #1;
      check("identity_result", host_rdata, 32'(i + 1));
    end

    // run 2: random data, tready 1,0,0,1, a few not-done polls
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    load_mem();
    start_run(1, 0, 0, $urandom_range(1, 5), 0, 0);
    wait_end("run2_end", 800);
    check_run(0);

    // run 3: awready three cycles late, wready immediate
    start_run(0, 3, 0, 0, 0, 0);
    wait_end("run3_end", 500);
    check_run(0);
    check("awvalid_cycles", awv_cyc, 8);
    check("wvalid_cycles", wv_cyc, 2);

    // run 4: ap_done never set
    start_run(0, 0, 0, 100000, 0, 0);
    wait_end("run4_end", 3000);
    check_run(1);

    // run 5: asynchronous reset after 10 stream beats, then rerun
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    load_mem();
    start_run(0, 0, 0, 0, 0, 0);
    n = 0;
    while (sm_data_q.size() < 10 && n < 200) begin
      @(negedge axis_clk); #1;
      n++;
    end
    check("beats_before_reset", sm_data_q.size(), 10);
    #2 axis_rst_n = 0;
    #1;
    check_idle("abort");
    check("abort_done", done, 0);
    repeat (2) @(negedge axis_clk);
    #1 axis_rst_n = 1;
    model_busy = 0;
    start_run(2, 0, 1, 1, 0, 0);
    wait_end("run5_end", 1500);
    check_run(0);

    // run 6: go with host_we, then writes and go while busy
    start_run(0, 0, 0, 2, 1, $urandom);
    repeat (5) @(negedge axis_clk);
    check("run6_busy", busy, 1);
    host_write(5'd5, ~mem[5]);
    @(negedge axis_clk); #1;
    go = 1;
    @(negedge axis_clk); #1;
    go = 0;
    wait_end("run6_end", 800);
    check_run(0);
    repeat (20) @(negedge axis_clk);
    check("no_second_run", sm_data_q.size(), 32);
    check("no_second_write", w_data_q.size(), 2);
    check("idle_busy", busy, 0);
    check("done_sticky", done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
